// File: rtl/rast_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rast_pkg: shared rasterizer front-end defaults, arbiter state type |
// | and MSAA encoding helper.                         Revision: 1.0    |
// +--------------------------------------------------------------------+
package rast_pkg;
  localparam int SIGFIG = 24;
  localparam int RADIX  = 10;
  localparam int VERTS  = 3;
  localparam int AXIS   = 3;
  localparam int COLORS = 3;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    CFG   = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic        legal;
    logic [3:0]  sub;
    logic [31:0] lg2;
  } msaa_enc_t;

  // Subsample interval is one-hot, widest interval for no MSAA.
  function automatic msaa_enc_t msaa_encode(input logic [31:0] msaa);
    msaa_enc_t e;
    e.legal = 1'b1;
    e.sub   = 4'b0100;
    e.lg2   = 32'd1;
    case (msaa)
      32'd1:   begin e.sub = 4'b1000; e.lg2 = 32'd0; end
      32'd4:   begin e.sub = 4'b0100; e.lg2 = 32'd1; end
      32'd16:  begin e.sub = 4'b0010; e.lg2 = 32'd2; end
      32'd64:  begin e.sub = 4'b0001; e.lg2 = 32'd3; end
      default: e.legal = 1'b0;
    endcase
    return e;
  endfunction
endpackage
`default_nettype wire

// File: rtl/rast_backface_cull.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rast_backface_cull: combinational winding check on x/y; flags      |
// | triangles whose cross-product z is non-negative.  Revision: 1.0    |
// +--------------------------------------------------------------------+
module rast_backface_cull #(
  parameter int SIGFIG = rast_pkg::SIGFIG,
  parameter int VERTS  = rast_pkg::VERTS,
  parameter int AXIS   = rast_pkg::AXIS
) (
  input  logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_in,
  output logic                                          to_cull
);
  localparam int EW = SIGFIG + 1;
  localparam int CW = 2 * SIGFIG + 3;

  function automatic logic signed [EW-1:0] sx_e(input logic [SIGFIG-1:0] v);
    return {v[SIGFIG-1], v};
  endfunction

  function automatic logic signed [CW-1:0] sx_c(input logic [EW-1:0] v);
    return {{(CW-EW){v[EW-1]}}, v};
  endfunction

  logic signed [EW-1:0] e0x, e0y, e1x, e1y;
  logic signed [CW-1:0] cz;
  logic                 unused_z;

  assign e0x = sx_e(tri_in[1][0]) - sx_e(tri_in[0][0]);
  assign e0y = sx_e(tri_in[1][1]) - sx_e(tri_in[0][1]);
  assign e1x = sx_e(tri_in[2][0]) - sx_e(tri_in[1][0]);
  assign e1y = sx_e(tri_in[2][1]) - sx_e(tri_in[1][1]);

  assign cz      = sx_c(e0x) * sx_c(e1y) - sx_c(e0y) * sx_c(e1x);
  assign to_cull = ~cz[CW-1];

  // Depth and any extra axes do not affect facing.
  assign unused_z = ^{tri_in[0][AXIS-1:2], tri_in[1][AXIS-1:2], tri_in[2][AXIS-1:2]};
endmodule
`default_nettype wire

// File: rtl/rast_tri_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rast_tri_arbiter: round-robin triangle port sharing, back-face     |
// | culling and drained screen/MSAA reconfiguration.  Revision: 1.0    |
// +--------------------------------------------------------------------+
module rast_tri_arbiter #(
  parameter int SIGFIG    = rast_pkg::SIGFIG,
  parameter int RADIX     = rast_pkg::RADIX,
  parameter int VERTS     = rast_pkg::VERTS,
  parameter int AXIS      = rast_pkg::AXIS,
  parameter int COLORS    = rast_pkg::COLORS,
  parameter int NREQ      = 2,
  parameter int DRAIN_CYC = 4
) (
  input  logic                                                   clk,
  input  logic                                                   rst,
  input  logic [NREQ-1:0]                                        req_valid,
  output logic [NREQ-1:0]                                        req_ready,
  input  logic signed [NREQ-1:0][VERTS-1:0][AXIS-1:0][SIGFIG-1:0] req_tri,
  input  logic [NREQ-1:0][COLORS-1:0][SIGFIG-1:0]                req_color,
  input  logic                                                   halt_RnnnnL,
  output logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0]          tri_R10S,
  output logic [COLORS-1:0][SIGFIG-1:0]                          color_R10U,
  output logic                                                   validTri_R10H,
  output logic signed [1:0][SIGFIG-1:0]                          screen_RnnnnS,
  output logic [3:0]                                             subSample_RnnnnU,
  output logic [31:0]                                            ss_w_lg2_RnnnnS,
  input  logic                                                   cfg_req,
  input  logic [1:0][SIGFIG-1:0]                                 cfg_screen,
  input  logic [31:0]                                            cfg_msaa,
  output logic                                                   cfg_ack,
  output logic                                                   cfg_err,
  output logic [31:0]                                            tri_cnt,
  output logic [31:0]                                            cull_cnt
);
  import rast_pkg::*;

  localparam int RRW = $clog2(NREQ);
  localparam int DCW = $clog2(DRAIN_CYC + 1);
  localparam logic [SIGFIG-1:0] SCREEN_RST = SIGFIG'(32'd512 << RADIX);

  arb_state_t                             state;
  logic [RRW-1:0]                         rr_ptr, gnt_idx, rr_next, cand_idx;
  logic [DCW-1:0]                         idle_cnt;
  logic                                   gnt_found, grant_en, xfer, out_free, to_cull;
  logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] sel_tri;
  logic [COLORS-1:0][SIGFIG-1:0]          sel_color;
  msaa_enc_t                              enc;
  int                                     cand;

  assign xfer     = validTri_R10H & halt_RnnnnL;
  assign out_free = ~validTri_R10H | xfer;
  assign grant_en = (state == RUN) & ~cfg_req & out_free & gnt_found;
  assign rr_next  = (gnt_idx == RRW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;

  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand     = (int'(rr_ptr) + k) % NREQ;
      cand_idx = RRW'(cand);
      if (!gnt_found && req_valid[cand_idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (grant_en) req_ready[gnt_idx] = 1'b1;
  end

  assign sel_tri   = req_tri[gnt_idx];
  assign sel_color = req_color[gnt_idx];

  rast_backface_cull #(
    .SIGFIG (SIGFIG),
    .VERTS  (VERTS),
    .AXIS   (AXIS)
  ) u_cull (
    .tri_in  (sel_tri),
    .to_cull (to_cull)
  );

  assign enc     = msaa_encode(cfg_msaa);
  assign cfg_ack = (state == CFG) &  enc.legal;
  assign cfg_err = (state == CFG) & ~enc.legal;

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= RUN;
      rr_ptr           <= '0;
      idle_cnt         <= '0;
      validTri_R10H    <= 1'b0;
      tri_R10S         <= '0;
      color_R10U       <= '0;
      screen_RnnnnS    <= {SCREEN_RST, SCREEN_RST};
      subSample_RnnnnU <= 4'b0100;
      ss_w_lg2_RnnnnS  <= 32'd1;
      tri_cnt          <= '0;
      cull_cnt         <= '0;
    end else begin
      if (xfer) begin
        validTri_R10H <= 1'b0;
        tri_cnt       <= tri_cnt + 32'd1;
      end
      // A fresh load in the same cycle as a transfer keeps valid high.
      if (grant_en) begin
        rr_ptr <= rr_next;
        if (to_cull) begin
          cull_cnt <= cull_cnt + 32'd1;
        end else begin
          tri_R10S      <= sel_tri;
          color_R10U    <= sel_color;
          validTri_R10H <= 1'b1;
        end
      end

      case (state)
        RUN: begin
          if (cfg_req) begin
            state    <= DRAIN;
            idle_cnt <= '0;
          end
        end
        DRAIN: begin
          if (!validTri_R10H && halt_RnnnnL) begin
            if (idle_cnt == DCW'(DRAIN_CYC - 1)) state <= CFG;
            else idle_cnt <= idle_cnt + 1'b1;
          end else begin
            idle_cnt <= '0;
          end
        end
        CFG: begin
          if (enc.legal) begin
            screen_RnnnnS    <= cfg_screen;
            subSample_RnnnnU <= enc.sub;
            ss_w_lg2_RnnnnS  <= enc.lg2;
          end
          state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_rast_tri_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_rast_tri_arbiter: scoreboard bench for the triangle arbiter.    |
// |                                                   Revision: 1.0    |
// +--------------------------------------------------------------------+
module tb_rast_tri_arbiter;
  localparam int DRAIN_CYC = 4;

  typedef logic [2:0][2:0][23:0] tri_t;
  typedef logic [2:0][23:0]      col_t;
  typedef struct packed {
    tri_t t;
    col_t c;
  } item_t;

  logic                           clk = 1'b0;
  logic                           rst;
  logic [1:0]                     req_valid;
  logic [1:0]                     req_ready;
  logic signed [1:0][2:0][2:0][23:0] req_tri;
  logic [1:0][2:0][23:0]          req_color;
  logic                           halt_RnnnnL;
  logic signed [2:0][2:0][23:0]   tri_R10S;
  logic [2:0][23:0]               color_R10U;
  logic                           validTri_R10H;
  logic signed [1:0][23:0]        screen_RnnnnS;
  logic [3:0]                     subSample_RnnnnU;
  logic [31:0]                    ss_w_lg2_RnnnnS;
  logic                           cfg_req;
  logic [1:0][23:0]               cfg_screen;
  logic [31:0]                    cfg_msaa;
  logic                           cfg_ack, cfg_err;
  logic [31:0]                    tri_cnt, cull_cnt;

  rast_tri_arbiter #(.NREQ(2), .DRAIN_CYC(DRAIN_CYC)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_tri(req_tri), .req_color(req_color), .halt_RnnnnL(halt_RnnnnL),
    .tri_R10S(tri_R10S), .color_R10U(color_R10U), .validTri_R10H(validTri_R10H),
    .screen_RnnnnS(screen_RnnnnS), .subSample_RnnnnU(subSample_RnnnnU),
    .ss_w_lg2_RnnnnS(ss_w_lg2_RnnnnS), .cfg_req(cfg_req), .cfg_screen(cfg_screen),
    .cfg_msaa(cfg_msaa), .cfg_ack(cfg_ack), .cfg_err(cfg_err),
    .tri_cnt(tri_cnt), .cull_cnt(cull_cnt)
  );

  always #5 clk = ~clk;

  int    checks = 0, errors = 0;
  item_t src0[$], src1[$], sb[$];
  int    grant_log[$], grant_cyc[$];
  int    grants_total = 0, valid_cycles = 0, cyc = 0, exp_rr = 0;
  logic [1:0] acc_s = '0;

  function automatic item_t mk(input int x0, y0, x1, y1, x2, y2, tag);
    item_t it;
    it.t[0][0] = 24'(x0); it.t[0][1] = 24'(y0);
    it.t[1][0] = 24'(x1); it.t[1][1] = 24'(y1);
    it.t[2][0] = 24'(x2); it.t[2][1] = 24'(y2);
    for (int v = 0; v < 3; v++) it.t[v][2] = 24'(tag * 8 + v);
    for (int c = 0; c < 3; c++) it.c[c] = 24'(tag * 16 + c + 1);
    return it;
  endfunction

  function automatic item_t front(input int k);
    return mk(k * 4096, 0, k * 4096, 1024, k * 4096 + 1024, 0, k);
  endfunction

  function automatic item_t rev(input int k);
    return mk(k * 4096 + 1024, 0, k * 4096, 1024, k * 4096, 0, k);
  endfunction

  function automatic bit tb_culled(input item_t it);
    longint x0 = longint'($signed(it.t[0][0]));
    longint y0 = longint'($signed(it.t[0][1]));
    longint x1 = longint'($signed(it.t[1][0]));
    longint y1 = longint'($signed(it.t[1][1]));
    longint x2 = longint'($signed(it.t[2][0]));
    longint y2 = longint'($signed(it.t[2][1]));
    return ((x1 - x0) * (y2 - y1) - (y1 - y0) * (x2 - x1)) >= 0;
  endfunction

  // Requester model: pops accepted triangles, scoreboards front-facing ones.
  initial forever begin
    item_t it;
    @(posedge clk);
    #1;
    cyc++;
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        if (acc_s[i]) begin
          if ((i == 0 && src0.size() == 0) || (i == 1 && src1.size() == 0)) begin
            checks++; errors++;
            $display("FAIL grant_idle requester=%0d had nothing to send", i);
          end else begin
            it = (i == 0) ? src0.pop_front() : src1.pop_front();
            grants_total++;
            grant_log.push_back(i);
            grant_cyc.push_back(cyc);
            if (!tb_culled(it)) sb.push_back(it);
          end
        end
      end
    end
    acc_s = '0;
    req_valid[0] = (src0.size() != 0);
    req_valid[1] = (src1.size() != 0);
    req_tri[0]   = (src0.size() != 0) ? src0[0].t : '0;
    req_color[0] = (src0.size() != 0) ? src0[0].c : '0;
    req_tri[1]   = (src1.size() != 0) ? src1[0].t : '0;
    req_color[1] = (src1.size() != 0) ? src1[0].c : '0;
  end

  // Output monitor: round-robin order and scoreboard comparison on transfers.
  initial forever begin
    item_t exp_it;
    int    idx;
    @(negedge clk);
    acc_s = req_ready;
    if (rst) begin
      exp_rr = 0;
    end else begin
      if (req_ready != 2'b00) begin
        idx = req_valid[exp_rr] ? exp_rr : 1 - exp_rr;
        checks++;
        if (req_ready !== 2'(1 << idx)) begin
          errors++;
          $display("FAIL rr_order req_ready=%b expected=%b", req_ready, 2'(1 << idx));
        end
        exp_rr = (idx + 1) % 2;
      end
      if (validTri_R10H) valid_cycles++;
      if (validTri_R10H && halt_RnnnnL) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_transfer tri=%h", tri_R10S);
        end else begin
          exp_it = sb.pop_front();
          if ({tri_R10S, color_R10U} !== exp_it) begin
            errors++;
            $display("FAIL tri_data got=%h expected=%h", {tri_R10S, color_R10U}, exp_it);
          end
        end
      end
    end
  end

  task automatic wait_drained(input string name);
    int n = 0;
    while ((src0.size() != 0 || src1.size() != 0 || sb.size() != 0 || validTri_R10H) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      checks++; errors++;
      $display("FAIL %s drain_timeout src0=%0d src1=%0d sb=%0d", name, src0.size(), src1.size(), sb.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; halt_RnnnnL = 1'b1; cfg_req = 1'b0; cfg_msaa = 32'd4; cfg_screen = '0;
    req_valid = '0; req_tri = '0; req_color = '0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    checks += 12;
    if (validTri_R10H !== 1'b0)       begin errors++; $display("FAIL rst_valid got=%b want=0", validTri_R10H); end
    if (req_ready !== 2'b00)          begin errors++; $display("FAIL rst_ready got=%b want=00", req_ready); end
    if (tri_R10S !== '0)              begin errors++; $display("FAIL rst_tri got=%h want=0", tri_R10S); end
    if (color_R10U !== '0)            begin errors++; $display("FAIL rst_color got=%h want=0", color_R10U); end
    if (screen_RnnnnS[0] !== 24'h080000) begin errors++; $display("FAIL rst_screen0 got=%h want=080000", screen_RnnnnS[0]); end
    if (screen_RnnnnS[1] !== 24'h080000) begin errors++; $display("FAIL rst_screen1 got=%h want=080000", screen_RnnnnS[1]); end
    if (subSample_RnnnnU !== 4'b0100) begin errors++; $display("FAIL rst_subsample got=%b want=0100", subSample_RnnnnU); end
    if (ss_w_lg2_RnnnnS !== 32'd1)    begin errors++; $display("FAIL rst_lg2 got=%0d want=1", ss_w_lg2_RnnnnS); end
    if (tri_cnt !== 32'd0)            begin errors++; $display("FAIL rst_tri_cnt got=%0d want=0", tri_cnt); end
    if (cull_cnt !== 32'd0)           begin errors++; $display("FAIL rst_cull_cnt got=%0d want=0", cull_cnt); end
    if (cfg_ack !== 1'b0)             begin errors++; $display("FAIL rst_cfg_ack got=%b want=0", cfg_ack); end
    if (cfg_err !== 1'b0)             begin errors++; $display("FAIL rst_cfg_err got=%b want=0", cfg_err); end
  endtask

  task automatic test_round_robin();
    int v0;
    grant_log.delete(); grant_cyc.delete();
    v0 = valid_cycles;
    src0.push_back(front(1)); src0.push_back(front(2));
    src1.push_back(front(3)); src1.push_back(front(4));
    wait_drained("rr");
    checks++;
    if (grant_log.size() != 4 || grant_log[0] != 0 || grant_log[1] != 1 || grant_log[2] != 0 || grant_log[3] != 1) begin
      errors++; $display("FAIL rr_sequence got=%p want=0,1,0,1", grant_log);
    end
    checks++;
    if (grant_cyc.size() != 4 || grant_cyc[3] - grant_cyc[0] != 3) begin
      errors++; $display("FAIL rr_back_to_back grant cycles=%p want 4 consecutive", grant_cyc);
    end
    checks++;
    if (valid_cycles - v0 != 4) begin errors++; $display("FAIL rr_valid_cycles got=%0d want=4", valid_cycles - v0); end
    checks++;
    if (tri_cnt !== 32'd4) begin errors++; $display("FAIL rr_tri_cnt got=%0d want=4", tri_cnt); end
  endtask

  task automatic test_cull();
    int v0, g0;
    v0 = valid_cycles; g0 = grants_total;
    src0.push_back(rev(5));
    wait_drained("cull");
    repeat (2) @(negedge clk);
    checks += 4;
    if (grants_total - g0 != 1) begin errors++; $display("FAIL cull_accepted got=%0d want=1", grants_total - g0); end
    if (valid_cycles != v0)     begin errors++; $display("FAIL cull_valid got=%0d want=0", valid_cycles - v0); end
    if (cull_cnt !== 32'd1)     begin errors++; $display("FAIL cull_cnt got=%0d want=1", cull_cnt); end
    if (tri_cnt !== 32'd4)      begin errors++; $display("FAIL cull_tri_cnt got=%0d want=4", tri_cnt); end
  endtask

  task automatic test_halt();
    tri_t        cap;
    logic [31:0] cnt;
    int          n = 0;
    @(posedge clk); #2 halt_RnnnnL = 1'b0;
    src0.push_back(front(6)); src1.push_back(front(7));
    while (!validTri_R10H && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (!validTri_R10H) begin errors++; $display("FAIL halt_load_timeout valid=%b", validTri_R10H); end
    cap = tri_R10S; cnt = tri_cnt;
    repeat (5) begin
      @(negedge clk);
      checks++;
      if (validTri_R10H !== 1'b1 || req_ready !== 2'b00 || tri_R10S !== cap) begin
        errors++;
        $display("FAIL halt_hold valid=%b ready=%b tri=%h want valid=1 ready=00 tri=%h", validTri_R10H, req_ready, tri_R10S, cap);
      end
    end
    @(posedge clk); #2 halt_RnnnnL = 1'b1;
    checks++;
    if (tri_cnt !== cnt) begin errors++; $display("FAIL halt_no_early_xfer got=%0d want=%0d", tri_cnt, cnt); end
    @(posedge clk); #2;
    checks++;
    if (tri_cnt !== cnt + 32'd1) begin errors++; $display("FAIL halt_release_xfer got=%0d want=%0d", tri_cnt, cnt + 32'd1); end
    wait_drained("halt");
    checks++;
    if (tri_cnt !== 32'd6) begin errors++; $display("FAIL halt_tri_cnt got=%0d want=6", tri_cnt); end
  endtask

  task automatic test_cfg();
    int g0, n = 0, ack_n = 0;
    logic [31:0] t0;
    t0 = tri_cnt;
    for (int k = 0; k < 6; k++) begin src0.push_back(front(10 + k)); src1.push_back(front(20 + k)); end
    repeat (3) @(posedge clk);
    #2;
    cfg_screen = {24'h040000, 24'h040000}; cfg_msaa = 32'd16; cfg_req = 1'b1;
    g0 = grants_total;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (cfg_ack) ack_n++;
      if (cfg_ack || cfg_err) break;
    end
    checks += 3;
    if (ack_n != 1 || cfg_err !== 1'b0) begin errors++; $display("FAIL cfg_ack_seen ack=%0d err=%b want ack=1 err=0", ack_n, cfg_err); end
    if (n != DRAIN_CYC + 2) begin errors++; $display("FAIL cfg_latency got=%0d want=%0d", n, DRAIN_CYC + 2); end
    if (grants_total != g0) begin errors++; $display("FAIL cfg_grants_stopped got=%0d want=0", grants_total - g0); end
    cfg_req = 1'b0;
    @(posedge clk); #2;
    checks += 3;
    if (subSample_RnnnnU !== 4'b0010) begin errors++; $display("FAIL cfg_subsample got=%b want=0010", subSample_RnnnnU); end
    if (ss_w_lg2_RnnnnS !== 32'd2)    begin errors++; $display("FAIL cfg_lg2 got=%0d want=2", ss_w_lg2_RnnnnS); end
    if (screen_RnnnnS !== {24'h040000, 24'h040000}) begin errors++; $display("FAIL cfg_screen got=%h want=040000040000", screen_RnnnnS); end
    @(negedge clk);
    checks++;
    if (cfg_ack !== 1'b0) begin errors++; $display("FAIL cfg_ack_pulse got=%b want=0", cfg_ack); end
    wait_drained("cfg");
    checks++;
    if (tri_cnt - t0 !== 32'd12) begin errors++; $display("FAIL cfg_resume got=%0d want=12", tri_cnt - t0); end
  endtask

  task automatic test_cfg_err();
    int n = 0, err_n = 0, ack_n = 0;
    logic [31:0] t0;
    @(posedge clk); #2;
    cfg_screen = {24'h010000, 24'h010000}; cfg_msaa = 32'd8; cfg_req = 1'b1;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (cfg_ack) ack_n++;
      if (cfg_err) err_n++;
      if (cfg_ack || cfg_err) break;
    end
    checks++;
    if (err_n != 1 || ack_n != 0) begin errors++; $display("FAIL err_pulse err=%0d ack=%0d want err=1 ack=0", err_n, ack_n); end
    cfg_req = 1'b0;
    @(posedge clk); #2;
    checks += 3;
    if (subSample_RnnnnU !== 4'b0010) begin errors++; $display("FAIL err_subsample got=%b want=0010", subSample_RnnnnU); end
    if (ss_w_lg2_RnnnnS !== 32'd2)    begin errors++; $display("FAIL err_lg2 got=%0d want=2", ss_w_lg2_RnnnnS); end
    if (screen_RnnnnS !== {24'h040000, 24'h040000}) begin errors++; $display("FAIL err_screen got=%h want=040000040000", screen_RnnnnS); end
    @(negedge clk);
    checks++;
    if (cfg_err !== 1'b0) begin errors++; $display("FAIL err_single got=%b want=0", cfg_err); end
    t0 = tri_cnt;
    src0.push_back(front(30)); src1.push_back(front(31)); src0.push_back(rev(32));
    wait_drained("err");
    checks += 2;
    if (tri_cnt - t0 !== 32'd2) begin errors++; $display("FAIL err_resume got=%0d want=2", tri_cnt - t0); end
    if (cull_cnt !== 32'd2)     begin errors++; $display("FAIL err_cull_cnt got=%0d want=2", cull_cnt); end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_round_robin();
    test_cull();
    test_halt();
    test_cfg();
    test_cfg_err();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
